// File: rtl/program_loader.sv
// Framed byte-stream loader for the instruction memory load port.
// Assembles big-endian words from a counted stream and releases the core only after a clean load.
module program_loader #(
  parameter int WORDS   = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [31:0]       load_mem_data,
  output logic              core_hold,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam logic [8:0]  WORDS_L   = 9'(WORDS);
  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          remaining_q, remaining_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         idle_q, idle_d;
  logic                hold_q, hold_d;

  logic                accept;
  logic                hdr_bad;
  logic [16:0]         idle_inc;
  logic                timeout_hit;

  assign accept      = in_valid && in_ready;
  assign hdr_bad     = (in_data == 8'd0) || ({1'b0, in_data} > WORDS_L);
  assign idle_inc    = {1'b0, idle_q} + 17'd1;
  // The idle cycle that brings the count up to TIMEOUT is the last one tolerated.
  assign timeout_hit = (idle_inc == TIMEOUT_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_cnt_q  <= '0;
      idle_q      <= '0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_q      <= idle_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_cnt_d  = byte_cnt_q;
    idle_d      = idle_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          hold_d  = 1'b1;
          idle_d  = '0;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (hdr_bad) begin
            state_d = S_ERR;
          end else begin
            remaining_d = in_data;
            addr_d      = '0;
            byte_cnt_d  = '0;
            idle_d      = '0;
            state_d     = S_DATA;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_inc[15:0];
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          idle_d     = '0;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_inc[15:0];
        end
      end
      S_WRITE: begin
        remaining_d = remaining_q - 8'd1;
        if (remaining_q == 8'd1) begin
          state_d = S_DONE;
        end else begin
          addr_d     = addr_q + ADDR_W'(1);
          byte_cnt_d = '0;
          idle_d     = '0;
          state_d    = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a decode of registered state; nothing flows through from inputs.
  assign in_ready      = (state_q == S_HDR) || (state_q == S_DATA);
  assign load_mem_en   = (state_q == S_WRITE);
  assign load_mem_addr = addr_q;
  assign load_mem_data = word_q;
  assign core_hold     = hold_q;
  assign core_rst_n    = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign busy          = (state_q == S_HDR) || (state_q == S_DATA) ||
                         (state_q == S_WRITE) || (state_q == S_DONE);
  assign err           = (state_q == S_ERR);

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that drives the instruction memory load port (`load_mem_en` / `load_mem_addr` / `load_mem_data`) of the instruction fetch stage. It accepts a framed byte stream (count header, then big-endian 32-bit words) over a valid/ready handshake. It writes each assembled word to consecutive instruction addresses starting at 0, and holds the core stalled until a complete, error-free program has been loaded. On success it pulses a core reset so the PC restarts at 0 with memory contents retained.

## Interface
- `WORDS`, 32: instruction memory depth in words; legal range 2..255.
- `ADDR_W`, 5: width of `load_mem_addr`; equals `$clog2(WORDS)`.
- `TIMEOUT`, 1024: maximum idle cycles between accepted bytes; legal range 1..65535.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begins a load session; honoured only in IDLE or ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `load_mem_en`  out  1  one-cycle write strobe to instruction memory.
- `load_mem_addr`  out  ADDR_W  write word address.
- `load_mem_data`  out  32  write word.
- `core_hold`  out  1  core stall; high from reset until the first successful load.
- `core_rst_n`  out  1  one-cycle active-low core reset issued at load completion.
- `busy`  out  1  session in progress (states HDR, DATA, WRITE, DONE).
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  level; header or timeout error, cleared by the next accepted `start`.

## Operation
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- **IDLE**
  - `in_ready`=0.
  - `start` moves to HDR, sets `core_hold`=1, and clears `err`.
- **HDR**
  - `in_ready`=1.
  - On an accepted byte N:
    - If N==0 or N>WORDS, go to ERR.
    - Otherwise set remaining=N, addr=0, byte_cnt=0, and go to DATA.
- **DATA**
  - `in_ready`=1.
  - Each accepted byte does word <= {word[23:0], in_data} (MSB first) and byte_cnt+1.
  - The 4th byte (byte_cnt==3) moves to WRITE.
- **WRITE**
  - `in_ready`=0, `load_mem_en`=1, `load_mem_addr`=addr, `load_mem_data`=word.
  - remaining-1.
  - If remaining was 1, go to DONE; otherwise addr+1, byte_cnt=0, and return to DATA.
- **DONE**
  - `done`=1 and `core_rst_n`=0 for exactly this cycle, then go to IDLE.
  - `core_hold` falls on the IDLE entry edge.
- **ERR**
  - `err`=1, `core_hold`=1, `in_ready`=0.
  - Remains in ERR until `start`, which goes to HDR.
- **Timeout**
  - An idle counter runs in HDR and DATA.
  - It clears on state entry and on every accepted byte, and increments on every other cycle.
  - When it reaches TIMEOUT, go to ERR. No write is issued for a partially assembled word.
- **Ignored or non-effective inputs**
  - `start` in HDR, DATA, WRITE or DONE is ignored.
  - `in_valid` outside HDR/DATA has no effect.
- **Addressing**
  - addr never exceeds N-1 ≤ WORDS-1, so no wrap-around occurs.
  - Header validation guarantees this.
- **Error behaviour**
  - Words already written before an error remain in memory.
  - The core stays held until a later successful load.
- **Reset**
  - Reset at any point, including mid-session, returns to IDLE.
  - Reset values: `core_hold`=1, `core_rst_n`=1, `in_ready`=0, `load_mem_en`=0, `load_mem_addr`=0, `load_mem_data`=0, `busy`=0, `done`=0, `err`=0.
  - All counters reset to 0.

## Timing
- `start` sampled at edge t: HDR and `in_ready`=1 from cycle t+1.
- 4th byte of a word accepted at edge t: `load_mem_en` is high during cycle t+1 only; `in_ready` is low during cycle t+1.
  - Not last word: `in_ready`=1 again from cycle t+2.
  - Last word: DONE during cycle t+2 (`done`=1, `core_rst_n`=0); `core_hold`=0 and `busy`=0 from cycle t+3.
- Sustained throughput: 1 word per 5 cycles with `in_valid` held high.
- Timeout: with TIMEOUT idle cycles following the last accepted byte, `err`=1 from the next cycle.
- The fetch stage gives its load port priority over stall but not over its reset. `core_rst_n` is therefore never asserted while `load_mem_en` is high.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DATA → all outputs at reset values; a new `start` + header 1 + `00 00 00 01` loads addr 0 = 0x00000001.
- **Basic load:** `start`; bytes `02 12 34 56 78 9A BC DE F0` with `in_valid` high → writes (0, 0x12345678) then (1, 0x9ABCDEF0), 5 cycles apart; `done` and `core_rst_n`=0 in the same single cycle; `core_hold` falls the next cycle.
- **Header errors:** header 0x00 → `err`=1, no writes, `core_hold`=1; `start` clears `err`; header 0x21 (WORDS=32) → `err`=1.
- **Timeout:** TIMEOUT=16; header 1 then 2 data bytes, then `in_valid`=0 → `err`=1 exactly 17 cycles after the 2nd byte; `load_mem_en` never asserted.
- **Full depth with gaps:** header 0x20, 128 bytes with random `in_valid` gaps < TIMEOUT, and `start` pulsed mid-session → 32 writes at addresses 0..31 with correct data; `start` ignored; single `done`.
